// File: rtl/rast_pkg.sv
// Shared rasterizer types and constants: fixed-point widths, sample-walk states, step decode.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {WAIT_STATE, TEST_STATE} samp_state_t;

    // One-hot sub-sample code to a fixed-point step; anything not one-hot means a full pixel.
    function automatic logic [SIGFIG-1:0] decode_step(input logic [3:0] sub_sample, input int radix);
        logic [SIGFIG-1:0] one;
        one = SIGFIG'(1) << radix;
        case (sub_sample)
            4'b1000: return one;
            4'b0100: return one >> 1;
            4'b0010: return one >> 2;
            4'b0001: return one >> 3;
            default: return one;
        endcase
    endfunction

endpackage

// File: rtl/sample_sequencer.sv
// Walks every sample position of a triangle's bounding box in row-major order, one per
// unfrozen cycle, presenting each with the latched triangle and color downstream.
module sample_sequencer
    import rast_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                   validTri_R13H,
    input  logic [3:0]                             subSample_RnnnnU,
    input  logic                                   halt_RnnnnL,
    output logic                                   halt_RnnnnL_up,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                   validSamp_R14H
);

    samp_state_t                            state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [1:0][1:0][SIGFIG-1:0]            box_q, box_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic [1:0][SIGFIG-1:0]                 sample_q, sample_d;
    logic                                   valid_q, valid_d;

    // One extra bit so stepping past the upper-right bound cannot wrap back inside the box.
    logic signed [SIGFIG:0] nx, ny, ur_x, ur_y;
    logic                   degenerate;

    assign nx   = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    assign ny   = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    assign ur_x = $signed({box_q[1][0][SIGFIG-1], box_q[1][0]});
    assign ur_y = $signed({box_q[1][1][SIGFIG-1], box_q[1][1]});

    assign degenerate = ($signed(box_R13S[1][0]) < $signed(box_R13S[0][0])) ||
                        ($signed(box_R13S[1][1]) < $signed(box_R13S[0][1]));

    assign halt_RnnnnL_up = halt_RnnnnL && (state_q == WAIT_STATE);

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        step_d   = step_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        case (state_q)
            WAIT_STATE: begin
                // A degenerate box is consumed without touching any register.
                if (validTri_R13H && !degenerate) begin
                    tri_d    = tri_R13S;
                    color_d  = color_R13U;
                    box_d    = box_R13S;
                    step_d   = decode_step(subSample_RnnnnU, RADIX);
                    sample_d = box_R13S[0];
                    valid_d  = 1'b1;
                    state_d  = TEST_STATE;
                end
            end
            TEST_STATE: begin
                if (nx <= ur_x) begin
                    sample_d[0] = nx[SIGFIG-1:0];
                end else if (ny <= ur_y) begin
                    sample_d[0] = box_q[0][0];
                    sample_d[1] = ny[SIGFIG-1:0];
                end else begin
                    valid_d = 1'b0;
                    state_d = WAIT_STATE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_STATE;
            tri_q    <= '0;
            color_q  <= '0;
            box_q    <= '0;
            step_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else if (halt_RnnnnL) begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed and randomized check of sample_sequencer against a nested-loop model of the box walk.
module tb_sample_sequencer;
    import rast_pkg::*;

    logic                                   clk = 1'b0;
    logic                                   rst;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnL;
    logic                                   halt_RnnnnL_up;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         llx, lly, urx, ury;
        logic [3:0] sub;
        logic [215:0] t;
        logic [71:0]  c;
    } tri_req_t;

    always #5 clk = ~clk;

    sample_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .halt_RnnnnL_up   (halt_RnnnnL_up),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    task automatic check(input string tag, input logic [215:0] observed, input logic [215:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int step_of(input logic [3:0] s);
        case (s)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    function automatic tri_req_t make_req(input int llx, input int lly, input int urx, input int ury,
                                          input logic [3:0] sub);
        tri_req_t r;
        r.llx = llx; r.lly = lly; r.urx = urx; r.ury = ury; r.sub = sub;
        r.t = '0;
        r.c = '0;
        for (int k = 0; k < 7; k++) r.t = {r.t[183:0], 32'($urandom)};
        for (int k = 0; k < 3; k++) r.c = {r.c[39:0], 32'($urandom)};
        return r;
    endfunction

    task automatic drive(input tri_req_t r, input logic v);
        tri_R13S         = r.t;
        color_R13U       = r.c;
        box_R13S         = {24'(r.ury), 24'(r.urx), 24'(r.lly), 24'(r.llx)};
        subSample_RnnnnU = r.sub;
        validTri_R13H    = v;
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic walk(input tri_req_t r, input tri_req_t nxt, input bit hold_next,
                        input int freeze_at, input int freeze_len, input int reset_at);
        logic [47:0] exp_q[$];
        int          st;
        st = step_of(r.sub);
        for (int y = r.lly; y <= r.ury; y += st)
            for (int x = r.llx; x <= r.urx; x += st)
                exp_q.push_back({24'(y), 24'(x)});

        check("idle_halt_up", 216'(halt_RnnnnL_up), 216'(1'b1));
        drive(r, 1'b1);
        halt_RnnnnL = 1'b1;
        @(negedge clk);
        if (hold_next) drive(nxt, 1'b1);
        else           drive(make_req(-7, 3, 99, -5, 4'b0010), 1'b0);

        if (exp_q.size() == 0) begin
            check("drop_valid", 216'(validSamp_R14H), 216'(1'b0));
            check("drop_halt_up", 216'(halt_RnnnnL_up), 216'(1'b1));
            return;
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            check("samp_valid", 216'(validSamp_R14H), 216'(1'b1));
            check("sample", 216'(sample_R14S), 216'(exp_q[i]));
            check("test_halt_up", 216'(halt_RnnnnL_up), 216'(1'b0));
            if (i == 0) begin
                check("tri_latched", 216'(tri_R14S), r.t);
                check("color_latched", 216'(color_R14U), 216'(r.c));
            end
            if (i == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid", 216'(validSamp_R14H), 216'(1'b0));
                check("rst_halt_up", 216'(halt_RnnnnL_up), 216'(1'b1));
                check("rst_sample", 216'(sample_R14S), 216'(0));
                check("rst_tri", 216'(tri_R14S), 216'(0));
                return;
            end
            if (i == freeze_at) begin
                halt_RnnnnL = 1'b0;
                repeat (freeze_len) begin
                    @(negedge clk);
                    check("frz_valid", 216'(validSamp_R14H), 216'(1'b1));
                    check("frz_sample", 216'(sample_R14S), 216'(exp_q[i]));
                    check("frz_halt_up", 216'(halt_RnnnnL_up), 216'(1'b0));
                end
                halt_RnnnnL = 1'b1;
            end
            @(negedge clk);
        end
        check("end_valid", 216'(validSamp_R14H), 216'(1'b0));
        check("end_halt_up", 216'(halt_RnnnnL_up), 216'(1'b1));
    endtask

    initial begin
        tri_req_t a, b, none;
        none = make_req(0, 0, 0, 0, 4'b1000);
        rst = 1'b1;
        halt_RnnnnL = 1'b1;
        drive(none, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_valid", 216'(validSamp_R14H), 216'(1'b0));
        check("reset_halt_up", 216'(halt_RnnnnL_up), 216'(1'b1));
        check("reset_sample", 216'(sample_R14S), 216'(0));
        check("reset_tri", 216'(tri_R14S), 216'(0));
        check("reset_color", 216'(color_R14U), 216'(0));
        rst = 1'b0;

        walk(make_req(0, 0, 2048, 1024, 4'b1000), none, 1'b0, -1, 0, -1);
        walk(make_req(0, 0, 2048, 1024, 4'b0100), none, 1'b0, -1, 0, -1);
        walk(make_req(-1024, -1024, -1024, -1024, 4'b1000), none, 1'b0, -1, 0, -1);
        walk(make_req(1024, 0, 0, 0, 4'b1000), none, 1'b0, -1, 0, -1);
        walk(make_req(0, 1024, 2048, 0, 4'b1000), none, 1'b0, -1, 0, -1);
        walk(make_req(0, 0, 2048, 1024, 4'b1000), none, 1'b0, 1, 3, -1);
        walk(make_req(0, 0, 2048, 1024, 4'b1000), none, 1'b0, -1, 0, 3);
        walk(make_req(0, 0, 1024, 1024, 4'b0000), none, 1'b0, -1, 0, -1);

        a = make_req(0, 0, 2048, 1024, 4'b1000);
        b = make_req(-512, 256, 512, 768, 4'b0100);
        walk(a, b, 1'b1, -1, 0, -1);
        walk(b, none, 1'b0, -1, 0, -1);

        for (int n = 0; n < 25; n++) begin
            logic [3:0] sub;
            int st, llx, lly, urx, ury, frz;
            case ($urandom_range(0, 5))
                0: sub = 4'b1000;
                1: sub = 4'b0100;
                2: sub = 4'b0010;
                3: sub = 4'b0001;
                4: sub = 4'b0110;
                default: sub = 4'b0000;
            endcase
            st  = step_of(sub);
            llx = st * (int'($urandom_range(0, 10)) - 5);
            lly = st * (int'($urandom_range(0, 10)) - 5);
            urx = llx + st * int'($urandom_range(0, 3)) + int'($urandom_range(0, st - 1));
            ury = lly + st * int'($urandom_range(0, 3)) + int'($urandom_range(0, st - 1));
            if ($urandom_range(0, 7) == 0) urx = llx - st;
            frz = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            walk(make_req(llx, lly, urx, ury, sub), none, 1'b0, frz, int'($urandom_range(1, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
